// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw pushbutton, producing a clean level and press/release strobes.
// Optional held-button auto-repeat on press_pulse: define BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_COUNT      = 50,
  parameter int REPEAT_DELAY  = 2500,
  parameter int REPEAT_PERIOD = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int            CW      = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   press_reg, release_reg;
  logic                   fsm_press, fsm_release, rep_fire;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button};
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    level_next  = level_reg;
    fsm_press   = 1'b0;
    fsm_release = 1'b0;
    case (state_reg)
      IDLE: begin
        level_next = 1'b0;
        if (s) begin
          if (DB_COUNT == 1) begin
            state_next = PRESSED;
            level_next = 1'b1;
            fsm_press  = 1'b1;
          end else begin
            state_next = WAIT_PRESS;
            cnt_next   = CW'(1);
          end
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg >= DB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          level_next = 1'b1;
          fsm_press  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PRESSED: begin
        level_next = 1'b1;
        if (!s) begin
          if (DB_COUNT == 1) begin
            state_next  = IDLE;
            level_next  = 1'b0;
            fsm_release = 1'b1;
          end else begin
            state_next = WAIT_RELEASE;
            cnt_next   = CW'(1);
          end
        end
      end
      WAIT_RELEASE: begin
        // A bounce back high returns to PRESSED silently; level never dropped.
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg >= DB_LAST) begin
          state_next  = IDLE;
          cnt_next    = '0;
          level_next  = 1'b0;
          fsm_release = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_reg, rep_cnt_next, rep_target;
  logic          rep_armed_reg, rep_armed_next;
  logic          new_press;

  assign new_press  = (state_next == PRESSED) && (state_reg == IDLE || state_reg == WAIT_PRESS);
  assign rep_target = rep_armed_reg ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

  // Counts only while in PRESSED; WAIT_RELEASE holds it so release bounce keeps the cadence.
  always_comb begin
    rep_cnt_next   = rep_cnt_reg;
    rep_armed_next = rep_armed_reg;
    rep_fire       = 1'b0;
    if (new_press || state_next == IDLE) begin
      rep_cnt_next   = '0;
      rep_armed_next = 1'b0;
    end else if (state_reg == PRESSED) begin
      if (rep_cnt_reg + RW'(1) >= rep_target) begin
        rep_cnt_next   = '0;
        rep_armed_next = 1'b1;
        rep_fire       = 1'b1;
      end else begin
        rep_cnt_next = rep_cnt_reg + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_armed_reg <= rep_armed_next;
    end
  end
`else
  // Repeat parameters are positive, so this is constant zero; it only keeps them referenced.
  assign rep_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= fsm_press | rep_fire;
      release_reg <= fsm_release;
    end
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
endmodule
